rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Writer side of the instruction ROM. Receives a program image as a byte stream (valid/ready,
//  e.g. from a UART RX or debug bridge). Assembles little-endian 32-bit words and drives the ROM
//  write port, so programs can be reloaded without re-running the simulator/bitstream.
//  Holds the core stalled (busy) while a load is in progress.
// PARAMETERS
//  ADDR_BITS  12  byte-address width of the ROM; capacity CAP = 2**(ADDR_BITS-2) words
// PORTS
//  clk          in   1          clock; all state changes on rising edge
//  reset        in   1          synchronous, active-high reset
//  start        in   1          one-cycle pulse: begin new load (honoured only in DONE/ERROR)
//  in_data      in   8          stream byte
//  in_valid     in   1          in_data is valid
//  in_ready     out  1          loader accepts byte; transfer when in_valid && in_ready
//  wr_en        out  1          ROM write strobe, one cycle per word
//  wr_address   out  ADDR_BITS  byte address of the word written (RomAddress, multiple of 4)
//  wr_data      out  32         word written (UWord)
//  busy         out  1          load in progress (LEN or DATA state)
//  done         out  1          image fully written (DONE state)
//  error        out  1          header word count exceeded CAP (ERROR state)
//  word_count   out  ADDR_BITS-1  words written so far in the current load
// BEHAVIOUR
//  - Stream format: 4-byte LE header N (word count), then N words, each 4 bytes LE (byte 0 = bits 7:0).
//  - States: LEN (collect header), DATA (collect words), DONE, ERROR. Reset -> LEN.
//  - Reset values: state LEN, byte index 0, wr_en 0, wr_address 0, wr_data 0, word_count 0,
//    done 0, error 0, busy 1, in_ready 1.
//  - in_ready = 1 in LEN/DATA, 0 in DONE/ERROR (combinational from state only, never from in_valid).
//  - Byte index 0..3 advances only on a transfer; wraps 3->0 when the 4th byte is accepted.
//    Gaps in in_valid are allowed and have no effect.
//  - LEN: on 4th header byte, latch N (32 bit). N==0 -> DONE; N>CAP -> ERROR; else -> DATA.
//  - DATA: on 4th byte of a word, next cycle: wr_en=1, wr_data=assembled word,
//    wr_address=word_count*4 (pre-increment), and word_count increments.
//    When this is word N, state -> DONE in the same edge that raises wr_en.
//  - Write latency: wr_en is high exactly the cycle after the last byte of a word is accepted;
//    it is low in every other cycle. Back-to-back words give wr_en in consecutive word slots,
//    at most one write per 4 transfers.
//  - DONE/ERROR: hold; done/error = 1; wr_en 0. start -> LEN with byte index, word_count and
//    N cleared. start in LEN/DATA is ignored.
//  - Addresses never wrap: N<=CAP guarantees the last address is (CAP-1)*4.
//  - reset mid-load: abandon the partial word/header immediately, no write issued. Words
//    already written stay in ROM. The next byte is treated as header byte 0.
//  - reset wins over start when both are asserted in the same cycle.
// TESTING
//  1 stream 02 00 00 00 | 78 56 34 12 | EF BE AD DE, in_valid always 1
//    -> wr_en @0x000=0x12345678, then @0x004=0xDEADBEEF; done=1, word_count=2, in_ready=0.
//  2 same stream with in_valid low 1-3 random cycles between bytes
//    -> identical writes, exactly 2 wr_en pulses, each 1 cycle after the word's last byte.
//  3 header 00 00 00 00 -> done=1 one cycle after 4th byte; wr_en never asserted.
//  4 ADDR_BITS=12, header 01 04 00 00 (N=1025 > CAP=1024) -> error=1, busy=0, no writes.
//    Then start pulse -> LEN; a valid 1-word stream loads @0x000.
//  5 reset asserted after 2 bytes of word 1 -> no write for it. Outputs at reset values.
//    A full new stream of 1 word writes @0x000.
//  6 in DONE, hold in_valid=1 with data -> no transfer (in_ready=0), no writes.
//    start while busy is ignored (word_count unchanged).

Source files
------------

// File: rtl/rom_loader.sv
// Writer side of the instruction ROM: assembles a little-endian byte stream
// (word-count header followed by program words) into 32-bit ROM writes.
module rom_loader #(
  parameter int ADDR_BITS = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDR_BITS-1:0]   wr_address,
  output logic [31:0]            wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_BITS-2:0]   word_count
);

  localparam logic [31:0] CAP = 32'd1 << (ADDR_BITS - 2);

  typedef enum logic [1:0] {
    S_LEN   = 2'd0,
    S_DATA  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [31:0]            word_q, word_d;
  logic [31:0]            n_q, n_d;
  logic [ADDR_BITS-2:0]   word_count_q, word_count_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]   wr_address_q, wr_address_d;
  logic [31:0]            wr_data_q, wr_data_d;

  logic                   xfer_s;
  logic [31:0]            asm_word_s;
  logic [ADDR_BITS-2:0]   count_inc_s;

  // Bytes shift in from the top so byte 0 ends up in bits 7:0 after four transfers.
  assign in_ready    = (state_q == S_LEN) || (state_q == S_DATA);
  assign xfer_s      = in_valid && in_ready;
  assign asm_word_s  = {in_data, word_q[31:8]};
  assign count_inc_s = word_count_q + {{(ADDR_BITS-2){1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    n_d          = n_q;
    word_count_d = word_count_q;
    wr_en_d      = 1'b0;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    case (state_q)
      S_LEN: begin
        if (xfer_s) begin
          word_d     = asm_word_s;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            n_d = asm_word_s;
            if (asm_word_s == 32'd0) begin
              state_d = S_DONE;
            end else if (asm_word_s > CAP) begin
              state_d = S_ERROR;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_LEN;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          word_d     = asm_word_s;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wr_en_d      = 1'b1;
            wr_data_d    = asm_word_s;
            wr_address_d = {word_count_q[ADDR_BITS-3:0], 2'b00};
            word_count_d = count_inc_s;
            // N <= CAP, so the incremented count never overflows its register.
            if ({{(33-ADDR_BITS){1'b0}}, count_inc_s} == n_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_LEN;
          byte_idx_d   = 2'd0;
          word_count_d = '0;
          n_d          = 32'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_LEN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LEN;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
      n_q          <= 32'd0;
      word_count_q <= '0;
      wr_en_q      <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      n_q          <= n_d;
      word_count_q <= word_count_d;
      wr_en_q      <= wr_en_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign word_count = word_count_q;
  assign busy       = (state_q == S_LEN) || (state_q == S_DATA);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: expected ROM writes go into a scoreboard
// queue as words are driven and are popped when wr_en is observed.
module tb_rom_loader;

  localparam int AB = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AB-1:0] wr_address;
  logic [31:0]   wr_data;
  logic          busy, done, error;
  logic [AB-2:0] word_count;

  int            n_checks = 0;
  int            n_fail = 0;
  int            wr_pulses = 0;
  logic          last_flag = 1'b0;
  logic          wr_due = 1'b0;
  logic [AB-1:0] exp_addr = '0;
  logic [AB+31:0] sb[$];

  rom_loader #(.ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // A write is due exactly one cycle after the last byte of a data word is offered.
  always @(posedge clk) wr_due <= in_valid && last_flag && !reset;

  // Scoreboard monitor: checks wr_en timing every cycle and pops expected writes.
  always @(negedge clk) begin
    logic [AB+31:0] exp;
    n_checks++;
    if (wr_en !== wr_due) begin
      n_fail++;
      $display("FAIL wr_en_timing t=%0t got=%b want=%b", $time, wr_en, wr_due);
    end
    if (wr_en === 1'b1) begin
      wr_pulses++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%h data=%h want=none", wr_address, wr_data);
      end else begin
        exp = sb.pop_front();
        if ({wr_address, wr_data} !== exp) begin
          n_fail++;
          $display("FAIL write_content got=%h/%h want=%h/%h",
                   wr_address, wr_data, exp[AB+31:32], exp[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    @(negedge clk);
    in_data   = b;
    in_valid  = 1'b1;
    last_flag = last;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    last_flag = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic is_data, input int max_gap);
    if (is_data) begin
      sb.push_back({exp_addr, w});
      exp_addr = exp_addr + 12'd4;
    end
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], is_data && (i == 3), (max_gap == 0) ? 0 : int'($urandom_range(1, max_gap)));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    exp_addr = '0;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({in_ready, busy, done, error, wr_en, wr_address, wr_data, word_count} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 11'd0}) begin
      n_fail++;
      $display("FAIL %s got rdy=%b busy=%b done=%b err=%b wr=%b a=%h d=%h wc=%0d want 1 1 0 0 0 000 00000000 0",
               tag, in_ready, busy, done, error, wr_en, wr_address, wr_data, word_count);
    end
  endtask

  task automatic check_end(input string tag, input logic e_done, input logic e_err, input int e_wc);
    @(negedge clk);
    n_checks++;
    if ({done, error, busy, in_ready} !== {e_done, e_err, 1'b0, 1'b0} || word_count !== 11'(e_wc)) begin
      n_fail++;
      $display("FAIL %s got done=%b err=%b busy=%b rdy=%b wc=%0d want done=%b err=%b busy=0 rdy=0 wc=%0d",
               tag, done, error, busy, in_ready, word_count, e_done, e_err, e_wc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset_values");
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send_word(32'd2, 1'b0, 0);
    send_word(32'h12345678, 1'b1, 0);
    send_word(32'hDEADBEEF, 1'b1, 0);
    check_end("basic_done", 1'b1, 1'b0, 2);
  endtask

  task automatic test_gaps();
    int p0;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || word_count !== 11'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_to_len got busy=%b rdy=%b wc=%0d done=%b want 1 1 0 0", busy, in_ready, word_count, done);
    end
    p0 = wr_pulses;
    send_word(32'd2, 1'b0, 3);
    send_word(32'h12345678, 1'b1, 3);
    send_word(32'hDEADBEEF, 1'b1, 3);
    check_end("gaps_done", 1'b1, 1'b0, 2);
    n_checks++;
    if (wr_pulses - p0 != 2) begin
      n_fail++;
      $display("FAIL gaps_pulses got=%0d want=2", wr_pulses - p0);
    end
  endtask

  task automatic test_zero_len();
    int p0;
    pulse_start();
    p0 = wr_pulses;
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0, 0);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_early_done got=%b want=0", done);
    end
    send_byte(8'h00, 1'b0, 0);
    check_end("zero_done", 1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_pulses != p0) begin
      n_fail++;
      $display("FAIL zero_writes got=%0d want=0", wr_pulses - p0);
    end
  endtask

  task automatic test_error();
    int p0;
    pulse_start();
    p0 = wr_pulses;
    send_word(32'h00000401, 1'b0, 0);
    check_end("error_state", 1'b0, 1'b1, 0);
    n_checks++;
    if (wr_pulses != p0) begin
      n_fail++;
      $display("FAIL error_writes got=%0d want=0", wr_pulses - p0);
    end
    pulse_start();
    send_word(32'd1, 1'b0, 0);
    send_word(32'hA5A55A5A, 1'b1, 0);
    check_end("after_error_done", 1'b1, 1'b0, 1);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_word(32'd1, 1'b0, 0);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid_values");
    reset    = 1'b0;
    exp_addr = '0;
    send_word(32'd1, 1'b0, 0);
    send_word(32'hCAFEF00D, 1'b1, 0);
    check_end("reset_mid_done", 1'b1, 1'b0, 1);
  endtask

  task automatic test_done_hold();
    @(negedge clk);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || done !== 1'b1 || word_count !== 11'd1) begin
        n_fail++;
        $display("FAIL done_hold got rdy=%b done=%b wc=%0d want 0 1 1", in_ready, done, word_count);
      end
    end
    in_valid = 1'b0;
    pulse_start();
    send_word(32'd2, 1'b0, 0);
    send_word(32'h0BADC0DE, 1'b1, 1);
    pulse_start();
    n_checks++;
    if (word_count !== 11'd1 || busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ignored got wc=%0d busy=%b rdy=%b want 1 1 1", word_count, busy, in_ready);
    end
    exp_addr = 12'h004;
    send_word(32'hFEEDFACE, 1'b1, 0);
    check_end("back_to_back_done", 1'b1, 1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_error();
    test_reset_mid();
    test_done_hold();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
